// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   Four-phase sequencer for a two-road crossing (NS / EW) with an
//   emergency all-red override. Drives R/Y/G lamps and per-road
//   remaining-seconds counts for a downstream 7-segment driver.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   emg       in   emergency request, asynchronous level, active-high
//   ns_light  out  {red,yellow,green} NS lamps, one-hot
//   ew_light  out  {red,yellow,green} EW lamps, one-hot
//   dat_ns    out  NS remaining seconds, binary 0..99
//   dat_ew    out  EW remaining seconds, binary 0..99
//   tick_1s   out  one-clk pulse per second, registered
module traffic_phase_ctrl #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int G_TIME      = 25,
    parameter int Y_TIME      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       emg,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [7:0] dat_ns,
    output logic [7:0] dat_ew,
    output logic       tick_1s
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [6:0]    G_CNT   = 7'(G_TIME);
    localparam logic [6:0]    Y_CNT   = 7'(Y_TIME);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        EW_G,
        EW_Y,
        EMG
    } state_t;

    state_t        state;
    logic [6:0]    cnt;
    logic [PW-1:0] prescaler;
    logic          emg_meta;
    logic          emg_s;
    logic          tick;

    logic [2:0]    ns_nxt;
    logic [2:0]    ew_nxt;
    logic [7:0]    dns_nxt;
    logic [7:0]    dew_nxt;
    logic [7:0]    cnt_ext;
    logic [7:0]    cnt_plus_y;

    assign tick       = (prescaler == PRE_MAX);
    assign cnt_ext    = {1'b0, cnt};
    assign cnt_plus_y = cnt_ext + {1'b0, Y_CNT};

    // Lamp/count decode from the current state; registered below, so the
    // outputs trail the state/cnt update by one clock.
    always_comb begin
        ns_nxt  = LAMP_R;
        ew_nxt  = LAMP_R;
        dns_nxt = '0;
        dew_nxt = '0;
        case (state)
            NS_G: begin
                ns_nxt  = LAMP_G;
                dns_nxt = cnt_ext;
                dew_nxt = cnt_plus_y;   // red road waits out the yellow too
            end
            NS_Y: begin
                ns_nxt  = LAMP_Y;
                dns_nxt = cnt_ext;
                dew_nxt = cnt_ext;
            end
            EW_G: begin
                ew_nxt  = LAMP_G;
                dew_nxt = cnt_ext;
                dns_nxt = cnt_plus_y;
            end
            EW_Y: begin
                ew_nxt  = LAMP_Y;
                dew_nxt = cnt_ext;
                dns_nxt = cnt_ext;
            end
            default: begin
                ns_nxt  = LAMP_R;
                ew_nxt  = LAMP_R;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= NS_G;
            cnt       <= G_CNT;
            prescaler <= '0;
            emg_meta  <= 1'b0;
            emg_s     <= 1'b0;
            tick_1s   <= 1'b0;
            ns_light  <= LAMP_R;
            ew_light  <= LAMP_R;
            dat_ns    <= '0;
            dat_ew    <= '0;
        end else begin
            emg_meta <= emg;
            emg_s    <= emg_meta;
            tick_1s  <= tick;
            ns_light <= ns_nxt;
            ew_light <= ew_nxt;
            dat_ns   <= dns_nxt;
            dat_ew   <= dew_nxt;

            // Emergency outranks any tick or phase change in the same cycle.
            // The prescaler stays at 0 for the whole override, including the
            // exit cycle, so the first second after EMG is a full second.
            if (emg_s) begin
                state     <= EMG;
                prescaler <= '0;
            end else if (state == EMG) begin
                state     <= NS_G;
                cnt       <= G_CNT;
                prescaler <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
                if (tick) begin
                    if (cnt > 7'd1) begin
                        cnt <= cnt - 7'd1;
                    end else begin
                        case (state)
                            NS_G: begin
                                state <= NS_Y;
                                cnt   <= Y_CNT;
                            end
                            NS_Y: begin
                                state <= EW_G;
                                cnt   <= G_CNT;
                            end
                            EW_G: begin
                                state <= EW_Y;
                                cnt   <= Y_CNT;
                            end
                            default: begin
                                state <= NS_G;
                                cnt   <= G_CNT;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
//   Drives traffic_phase_ctrl with directed and random emergency traffic and
//   compares every output cycle against a phase/seconds-level model.
module tb_traffic_phase_ctrl;

    localparam int TC = 4;
    localparam int G  = 5;
    localparam int Y  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       emg = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] dat_ns;
    logic [7:0] dat_ew;
    logic       tick_1s;

    int checks = 0;
    int errors = 0;

    traffic_phase_ctrl #(
        .TICK_CYCLES(TC),
        .G_TIME     (G),
        .Y_TIME     (Y)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .emg     (emg),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .dat_ns  (dat_ns),
        .dat_ew  (dat_ew),
        .tick_1s (tick_1s)
    );

    always #5 clk = ~clk;

    // {ns_light, ew_light, dat_ns, dat_ew, tick_1s}
    logic [22:0] obs;
    assign obs = {ns_light, ew_light, dat_ns, dat_ew, tick_1s};

    localparam logic [22:0] RESET_OUT = {3'b100, 3'b100, 8'd0, 8'd0, 1'b0};
    localparam logic [22:0] START_OUT = {3'b001, 3'b100, 8'd5, 8'd7, 1'b0};

    // Reference model: phase 0..3 = NS green, NS yellow, EW green, EW yellow;
    // phase 4 = emergency. m_left is seconds left, m_cyc counts clocks since
    // the seconds timer last restarted.
    int          m_ph;
    int          m_left;
    int          m_cyc;
    bit          m_s1;
    bit          m_s2;
    logic [22:0] exp_out;

    function automatic logic [21:0] display(input int ph, input int left);
        case (ph)
            0:       return {3'b001, 3'b100, 8'(left), 8'(left + Y)};
            1:       return {3'b010, 3'b100, 8'(left), 8'(left)};
            2:       return {3'b100, 3'b001, 8'(left + Y), 8'(left)};
            3:       return {3'b100, 3'b010, 8'(left), 8'(left)};
            default: return {3'b100, 3'b100, 8'd0, 8'd0};
        endcase
    endfunction

    function automatic bit lamps_ok(input logic [22:0] o);
        logic [2:0] ns, ew;
        ns = o[22:20];
        ew = o[19:17];
        return $onehot(ns) && $onehot(ew) && (ns == 3'b100 || ew == 3'b100)
               && o[16:9] <= 8'd99 && o[8:1] <= 8'd99;
    endfunction

    task automatic model_reset();
        m_ph    = 0;
        m_left  = G;
        m_cyc   = 0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        exp_out = RESET_OUT;
    endtask

    task automatic model_edge();
        bit sec_end;
        sec_end = (m_cyc % TC) == TC - 1;
        exp_out = {display(m_ph, m_left), sec_end};
        if (m_s2) begin
            m_ph  = 4;
            m_cyc = 0;
        end else if (m_ph == 4) begin
            m_ph   = 0;
            m_left = G;
            m_cyc  = 0;
        end else begin
            m_cyc++;
            if (sec_end) begin
                if (m_left > 1) m_left--;
                else begin
                    m_ph   = (m_ph + 1) % 4;
                    m_left = (m_ph % 2 == 0) ? G : Y;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = emg;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic test_reset();
        int ticks;
        emg   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== RESET_OUT) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, RESET_OUT);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== START_OUT) begin
            errors++;
            $display("FAIL first_cycle: got %h expected %h", obs, START_OUT);
        end
        ticks = 0;
        for (int i = 0; i < 3 * TC; i++) begin
            step();
            ticks += int'(tick_1s);
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("FAIL reset_run cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++;
            $display("FAIL tick_period: got %0d ticks expected 3", ticks);
        end
    endtask

    task automatic test_full_cycle();
        for (int i = 0; i < 15 * TC; i++) begin
            step();
            checks++;
            if (obs !== exp_out || !lamps_ok(obs)) begin
                errors++;
                $display("FAIL full_cycle cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
    endtask

    task automatic test_emergency();
        int n;
        int first_red;
        n = 0;
        while (m_ph != 2 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (m_ph != 2) begin
            errors++;
            $display("FAIL emg_reach_ew_g: got phase %0d expected 2", m_ph);
        end
        emg = 1'b1;
        first_red = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (first_red == 0 && ns_light == 3'b100 && ew_light == 3'b100) first_red = i;
            checks++;
            if (obs !== exp_out || !lamps_ok(obs)) begin
                errors++;
                $display("FAIL emg_hold cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
        checks++;
        if (first_red < 1 || first_red > 4) begin
            errors++;
            $display("FAIL emg_latency: got %0d clks expected 1..4", first_red);
        end
        emg = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (obs !== exp_out || !lamps_ok(obs)) begin
                errors++;
                $display("FAIL emg_release cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
    endtask

    // The synchronised request lands on the very clock that ends NS yellow.
    task automatic test_emg_last_tick();
        int n;
        n = 0;
        while (!(m_ph == 1 && m_left == 1 && (m_cyc % TC) == TC - 3) && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (!(m_ph == 1 && m_left == 1)) begin
            errors++;
            $display("FAIL last_tick_setup: got phase %0d left %0d expected 1/1", m_ph, m_left);
        end
        emg = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs !== exp_out || ew_light === 3'b001) begin
                errors++;
                $display("FAIL last_tick_emg cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
        emg = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("FAIL last_tick_release cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (m_ph != 1 && n < 200) begin
            step();
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_OUT) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs, RESET_OUT);
        end
        model_reset();
        step();
        step();
        checks++;
        if (obs !== RESET_OUT) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obs, RESET_OUT);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== START_OUT) begin
            errors++;
            $display("FAIL reset_restart: got %h expected %h", obs, START_OUT);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("FAIL reset_resume cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) emg = ~emg;
            step();
            checks++;
            if (obs !== exp_out || !lamps_ok(obs)) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", i, obs, exp_out);
            end
        end
        emg = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_emergency();
        test_emg_last_tick();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
